// File: rtl/dsp_result_acc.sv
// Frame accumulator for the DSP P stream. It sums FRAME_LEN samples into one total and holds that total in a single output register.
// Latency: the total is valid one cycle after the last sample is accepted. Backpressure: p_ready falls only when a finished total is still waiting on acc_ready.
module dsp_result_acc #(
    parameter int P_WIDTH   = 48,
    parameter int ACC_WIDTH = 56,
    parameter int FRAME_LEN = 4,
    parameter int SATURATE  = 1,
    localparam int CNT_WIDTH = $clog2(FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [P_WIDTH-1:0]   p_in,
    input  logic                 p_valid,
    output logic                 p_ready,
    input  logic                 clr,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 overflow
);
    localparam int PAD = ACC_WIDTH + 1 - P_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 carry;
    logic [ACC_WIDTH-1:0] result;
    logic                 last_slot;
    logic                 in_xfer;
    logic                 out_xfer;

    // The extra top bit of sum_full is the carry out of ACC_WIDTH.
    assign sum_full  = {1'b0, acc} + {{PAD{1'b0}}, p_in};
    assign carry     = sum_full[ACC_WIDTH];
    assign result    = (carry && (SATURATE != 0)) ? {ACC_WIDTH{1'b1}} : sum_full[ACC_WIDTH-1:0];
    assign last_slot = (frame_cnt == LAST_IDX);

    // The last sample can enter only when the holding register is empty or is being drained in the same cycle.
    assign p_ready  = !clr && (!last_slot || !acc_valid || acc_ready);
    assign in_xfer  = p_valid && p_ready;
    assign out_xfer = acc_valid && acc_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            frame_cnt <= '0;
        end else if (clr) begin
            acc       <= '0;
            frame_cnt <= '0;
        end else if (in_xfer) begin
            if (last_slot) begin
                acc       <= '0;
                frame_cnt <= '0;
            end else begin
                acc       <= result;
                frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // The clear does not touch the holding register, so a pending total still drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out   <= '0;
            acc_valid <= 1'b0;
        end else if (in_xfer && last_slot) begin
            acc_out   <= result;
            acc_valid <= 1'b1;
        end else if (out_xfer) begin
            acc_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
        end else if (in_xfer && carry) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsp_result_acc.sv
// Directed bench for dsp_result_acc: one instance with the default parameters, plus 48-bit, two-sample instances with saturation and with wrap.
module tb_dsp_result_acc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] p_in;
    logic        p_valid;
    logic        p_ready;
    logic        clr;
    logic [55:0] acc_out;
    logic        acc_valid;
    logic        acc_ready;
    logic [2:0]  frame_cnt;
    logic        overflow;

    logic [47:0] t_in;
    logic        t_valid;
    logic        t_clr;
    logic        t_ready;
    logic        s_p_ready, w_p_ready;
    logic [47:0] s_acc_out, w_acc_out;
    logic        s_acc_valid, w_acc_valid;
    logic [1:0]  s_frame_cnt, w_frame_cnt;
    logic        s_overflow, w_overflow;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dsp_result_acc u_main (
        .clk(clk), .rst_n(rst_n), .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready), .clr(clr),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready), .frame_cnt(frame_cnt), .overflow(overflow)
    );

    dsp_result_acc #(.P_WIDTH(48), .ACC_WIDTH(48), .FRAME_LEN(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .p_in(t_in), .p_valid(t_valid), .p_ready(s_p_ready), .clr(t_clr),
        .acc_out(s_acc_out), .acc_valid(s_acc_valid), .acc_ready(t_ready), .frame_cnt(s_frame_cnt), .overflow(s_overflow)
    );

    dsp_result_acc #(.P_WIDTH(48), .ACC_WIDTH(48), .FRAME_LEN(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .p_in(t_in), .p_valid(t_valid), .p_ready(w_p_ready), .clr(t_clr),
        .acc_out(w_acc_out), .acc_valid(w_acc_valid), .acc_ready(t_ready), .frame_cnt(w_frame_cnt), .overflow(w_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample to the main instance. Wait for p_ready, within a bounded number of cycles.
    task automatic push(input logic [47:0] v);
        int n;
        n = 0;
        p_in    = v;
        p_valid = 1'b1;
        #1;
        while (!p_ready && n < 50) begin
            step();
            n++;
        end
        check("push_ready", 64'(p_ready), 64'd1);
        @(posedge clk);
        #1;
        p_valid = 1'b0;
    endtask

    initial begin
        logic [55:0] run_sum;
        logic [55:0] expq[$];
        logic [55:0] exp_tot;
        int          ns;
        int          frames_got;
        logic        a_x, i_x;

        rst_n = 1'b0; p_in = '0; p_valid = 1'b0; clr = 1'b0; acc_ready = 1'b1;
        t_in = '0; t_valid = 1'b0; t_clr = 1'b0; t_ready = 1'b1;
        step(); step();
        check("rst_acc_out", 64'(acc_out), 64'd0);
        check("rst_acc_valid", 64'(acc_valid), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        step();

        // Test 1: a reset in the middle of a frame, then the frame 1+2+3+4
        push(48'd1);
        push(48'd2);
        check("t1_cnt_pre", 64'(frame_cnt), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t1_rst_cnt", 64'(frame_cnt), 64'd0);
        check("t1_rst_valid", 64'(acc_valid), 64'd0);
        check("t1_rst_out", 64'(acc_out), 64'd0);
        #1;
        rst_n = 1'b1;
        step();
        push(48'd1); push(48'd2); push(48'd3);
        check("t1_valid_early", 64'(acc_valid), 64'd0);
        push(48'd4);
        check("t1_valid", 64'(acc_valid), 64'd1);
        check("t1_out", 64'(acc_out), 64'd10);
        check("t1_ovf", 64'(overflow), 64'd0);
        check("t1_cnt", 64'(frame_cnt), 64'd0);

        // Test 2: four maximum 48-bit samples fit in 56 bits
        for (int i = 0; i < 4; i++) push(48'hFFFF_FFFF_FFFF);
        check("t2_out", 64'(acc_out), 64'h3_FFFF_FFFF_FFFC);
        check("t2_ovf", 64'(overflow), 64'd0);

        // Test 3: backpressure on the last sample, then drain and accept in the same cycle
        step();
        acc_ready = 1'b0;
        push(48'd1); push(48'd2); push(48'd3); push(48'd4);
        check("t3_out10", 64'(acc_out), 64'd10);
        push(48'd5); push(48'd5); push(48'd5);
        check("t3_cnt3", 64'(frame_cnt), 64'd3);
        p_in = 48'd5; p_valid = 1'b1;
        #1;
        check("t3_ready_low", 64'(p_ready), 64'd0);
        step();
        check("t3_held_out", 64'(acc_out), 64'd10);
        check("t3_held_valid", 64'(acc_valid), 64'd1);
        check("t3_held_cnt", 64'(frame_cnt), 64'd3);
        acc_ready = 1'b1;
        #1;
        check("t3_ready_high", 64'(p_ready), 64'd1);
        step();
        p_valid = 1'b0; acc_ready = 1'b0;
        check("t3_out20", 64'(acc_out), 64'd20);
        check("t3_valid_nobubble", 64'(acc_valid), 64'd1);
        acc_ready = 1'b1;
        step();
        check("t3_drained", 64'(acc_valid), 64'd0);
        check("t3_out_kept", 64'(acc_out), 64'd20);

        // Test 4: 2^47 + 2^47 overflows a 48-bit accumulator
        t_in = 48'h8000_0000_0000; t_valid = 1'b1;
        step(); step();
        t_valid = 1'b0;
        check("t4_sat_out", 64'(s_acc_out), 64'hFFFF_FFFF_FFFF);
        check("t4_sat_ovf", 64'(s_overflow), 64'd1);
        check("t4_wrap_out", 64'(w_acc_out), 64'd0);
        check("t4_wrap_ovf", 64'(w_overflow), 64'd1);
        check("t4_wrap_valid", 64'(w_acc_valid), 64'd1);
        t_in = 48'd1; t_valid = 1'b1;
        step(); step();
        t_valid = 1'b0;
        check("t4_sat_next", 64'(s_acc_out), 64'd2);
        step(); step();
        check("t4_sat_sticky", 64'(s_overflow), 64'd1);
        check("t4_wrap_sticky", 64'(w_overflow), 64'd1);
        t_clr = 1'b1;
        step();
        t_clr = 1'b0;
        check("t4_sat_clr", 64'(s_overflow), 64'd0);
        check("t4_wrap_clr", 64'(w_overflow), 64'd0);

        // Test 5: a clear drops the sample offered in the same cycle and discards the partial frame
        push(48'd7); push(48'd7);
        check("t5_cnt2", 64'(frame_cnt), 64'd2);
        clr = 1'b1; p_in = 48'd7; p_valid = 1'b1;
        #1;
        check("t5_ready_clr", 64'(p_ready), 64'd0);
        step();
        clr = 1'b0; p_valid = 1'b0;
        check("t5_cnt0", 64'(frame_cnt), 64'd0);
        check("t5_ovf0", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) push(48'd5);
        check("t5_out20", 64'(acc_out), 64'd20);
        step();
        check("t5_drained", 64'(acc_valid), 64'd0);

        // Test 6: samples on alternate cycles with random acc_ready, checked against a reference sum
        run_sum = '0; ns = 0; frames_got = 0;
        for (int cyc = 0; cyc < 4000 && frames_got < 50; cyc++) begin
            p_valid   = cyc[0];
            p_in      = {16'($urandom), 32'($urandom)};
            acc_ready = 1'($urandom_range(0, 1));
            #1;
            a_x = acc_valid && acc_ready;
            i_x = p_valid && p_ready;
            if (a_x) begin
                exp_tot = (expq.size() > 0) ? expq.pop_front() : 56'hFF_FFFF_FFFF_FFFF;
                check("t6_total", 64'(acc_out), 64'(exp_tot));
                frames_got++;
            end
            if (i_x) begin
                run_sum = run_sum + 56'(p_in);
                ns++;
                if (ns == 4) begin
                    expq.push_back(run_sum);
                    run_sum = '0;
                    ns = 0;
                end
            end
            @(posedge clk);
            #1;
        end
        p_valid = 1'b0;
        check("t6_frames", 64'(frames_got), 64'd50);
        check("t6_ovf", 64'(overflow), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
